imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Byte-stream program loader sitting directly upstream of the pipelined RISC-V core. Receives a length-prefixed program image over a valid/ready byte interface, assembles little-endian 32-bit words, writes them sequentially into instruction memory, and holds the core in reset until the image is fully written. Its `core_reset` output drives the core's `reset` input, and its write port drives the instruction memory load port.

## Interface
- `ADDR_WIDTH`, 8, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_WIDTH  word address of the write.
- `imem_wdata`  out  32  assembled instruction word.
- `core_reset`  out  1  active-high reset to the core.
- `boot_done`  out  1  image loaded and core released; sticky.
- `boot_error`  out  1  load aborted; sticky; core held in reset.

Clock and reset: one clock; reset is asynchronous and active-high.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), N×4 data bytes (each word LSB first), then the checksum byte if configured.
- States: LEN_LO → LEN_HI → DATA → [CHK] → DONE; any state can go → ERROR as listed below.
- `rx_ready` = 1 in LEN_LO, LEN_HI, DATA and CHK; 0 in DONE and ERROR, and 0 while `reset` is high.
- A byte is accepted on a rising edge where `rx_valid & rx_ready`. Idle cycles between bytes are unbounded.
- After LEN_HI is accepted:
  - if N > 2^ADDR_WIDTH → ERROR;
  - else if N == 0 → CHK (macro defined) or DONE;
  - else → DATA.
- DATA:
  - A 2-bit byte counter fills `wdata[8k+7:8k]` for k = 0..3.
  - On the 4th byte, the word is latched to `imem_wdata`, `imem_addr` = word index, and `imem_we` pulses.
  - The word index increments after each write.
  - After word N-1 → CHK or DONE.
- DONE: `core_reset` falls and `boot_done` rises; the state is held until `reset`.
- ERROR: `boot_error` = 1, `core_reset` stays 1; held until `reset`.
- Word index width is ADDR_WIDTH+1 internally so that N = 2^ADDR_WIDTH does not wrap; `imem_addr` takes the low ADDR_WIDTH bits.

## Timing
- Reset values:
  - `rx_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0;
  - `core_reset` = 1, `boot_done` = 0, `boot_error` = 0;
  - state = LEN_LO, all counters 0.
- `imem_we`, `imem_addr` and `imem_wdata` are registered. The strobe is high for exactly the one cycle after the edge accepting a word's 4th byte.
- `core_reset` and `boot_done` are registered. They change on the edge after the final `imem_we` cycle, or on the edge after LEN_HI/CHK acceptance when N == 0. The core therefore never leaves reset while a write is in flight.
- Zero-bubble throughput: one byte per cycle; one write per 4 cycles.
- Reset asserted mid-load:
  - immediately forces all outputs to their reset values and aborts any partial word;
  - memory contents already written are not cleared;
  - the next stream restarts at word 0.
- `rx_data` is ignored whenever `rx_ready` = 0.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - after the last data byte (or after LEN_HI if N == 0), one checksum byte is expected in CHK;
  - it must equal the XOR of all preceding stream bytes, including LEN_LO and LEN_HI;
  - match → DONE; mismatch → ERROR, core held in reset.
  - Writes made before CHK remain in memory.
- `BOOT_CHECKSUM_EN` undefined: the CHK state and XOR accumulator are absent, and DATA/LEN_HI go straight to DONE.

## Test plan
- Normal load: N=2, bytes 02 00 13 00 00 00 93 00 50 00, back-to-back → `imem_we` pulses addr 0 data 0x00000013, then addr 1 data 0x00500093. `core_reset` falls and `boot_done`=1 one cycle after the second pulse.
- Gapped stream: same image with 0–5 random idle cycles between bytes → identical writes; `rx_ready` stays 1 until DONE.
- Zero-length: 00 00 (macro off) → no `imem_we`; `boot_done`=1 on the edge after LEN_HI acceptance.
- Overflow: ADDR_WIDTH=8, N=257 (01 01) → `boot_error`=1, `rx_ready`=0, `core_reset`=1, no writes.
- Mid-load reset: assert `reset` after 6 bytes of an N=2 image → outputs at reset values immediately. A new N=1 image writes to addr 0 and completes normally.
- Checksum (macro on): N=1, word 0x00000013, checksum 0x12 → DONE. Checksum 0x00 → ERROR, `core_reset` held at 1, but the addr-0 write was still issued.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed byte stream, assembles
// little-endian 32-bit words, writes them into instruction memory and keeps
// the core in reset until the whole image has been written.
// Optional feature macro: BOOT_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_boot_loader #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_reset,
   output logic                  boot_done,
   output logic                  boot_error
);

   // One extra bit so a full-capacity image does not wrap the index.
   localparam int unsigned IDX_W = ADDR_WIDTH + 1;
   localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

`ifdef BOOT_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_LEN_LO = 3'd0,
      S_LEN_HI = 3'd1,
      S_DATA   = 3'd2,
      S_CHK    = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_LEN_LO = 3'd0,
      S_LEN_HI = 3'd1,
      S_DATA   = 3'd2,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;
`endif

   state_t            state;
   state_t            nextState;
   logic              accept;
   logic [7:0]        lenLo;
   logic [15:0]       wordCount;
   logic [15:0]       lenFull;
   logic [1:0]        byteCnt;
   logic [IDX_W-1:0]  wordIdx;
   logic [23:0]       wordBuf;
   logic              lastWord;
   logic              tooLong;
   logic              readyNext;
   logic              weNext;
   logic              coreResetNext;
   logic              doneNext;
   logic              errorNext;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]        xorAcc;
`endif

   assign accept   = rx_valid & rx_ready;
   assign lenFull  = {rx_data, lenLo};
   assign tooLong  = 17'(lenFull) > CAPACITY;
   assign lastWord = (17'(wordIdx) + 17'd1) == 17'(wordCount);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_LEN_LO;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: walk the stream format, divert to ERROR on bad input.
   always_comb begin
      nextState = state;
      case (state)
         S_LEN_LO: begin
            if (accept) nextState = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (accept) begin
               if (tooLong) begin
                  nextState = S_ERROR;
               end else if (lenFull == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                  nextState = S_CHK;
`else
                  nextState = S_DONE;
`endif
               end else begin
                  nextState = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept && byteCnt == 2'd3 && lastWord) begin
`ifdef BOOT_CHECKSUM_EN
               nextState = S_CHK;
`else
               nextState = S_DONE;
`endif
            end
         end
`ifdef BOOT_CHECKSUM_EN
         S_CHK: begin
            if (accept) nextState = (rx_data == xorAcc) ? S_DONE : S_ERROR;
         end
`endif
         S_DONE:  nextState = S_DONE;
         S_ERROR: nextState = S_ERROR;
         default: nextState = S_ERROR;
      endcase
   end

   // Output decode; values are registered below so every port is a flop.
   always_comb begin
      readyNext     = 1'b0;
      weNext        = 1'b0;
      coreResetNext = 1'b1;
      doneNext      = 1'b0;
      errorNext     = 1'b0;
      case (nextState)
         S_LEN_LO, S_LEN_HI, S_DATA: readyNext = 1'b1;
`ifdef BOOT_CHECKSUM_EN
         S_CHK:                      readyNext = 1'b1;
`endif
         default:                    readyNext = 1'b0;
      endcase
      weNext = (state == S_DATA) && accept && (byteCnt == 2'd3);
      // Release follows the DONE state by one edge, so the last write lands first.
      if (state == S_DONE) begin
         coreResetNext = 1'b0;
         doneNext      = 1'b1;
      end
      errorNext = (state == S_ERROR);
   end

   // Output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_reset <= 1'b1;
         boot_done  <= 1'b0;
         boot_error <= 1'b0;
      end else begin
         rx_ready   <= readyNext;
         imem_we    <= weNext;
         core_reset <= coreResetNext;
         boot_done  <= doneNext;
         boot_error <= errorNext;
         if (weNext) begin
            imem_addr  <= wordIdx[ADDR_WIDTH-1:0];
            imem_wdata <= {rx_data, wordBuf};
         end
      end
   end

   // Length capture, byte/word counters and little-endian word assembly.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lenLo     <= '0;
         wordCount <= '0;
         byteCnt   <= '0;
         wordIdx   <= '0;
         wordBuf   <= '0;
      end else if (accept) begin
         case (state)
            S_LEN_LO: lenLo <= rx_data;
            S_LEN_HI: wordCount <= lenFull;
            S_DATA: begin
               byteCnt <= byteCnt + 2'd1;
               // Bytes arrive LSB first; shifting in from the top leaves
               // byte k at bits [8k+7:8k] once three bytes are in.
               wordBuf <= {rx_data, wordBuf[23:8]};
               if (byteCnt == 2'd3) wordIdx <= wordIdx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef BOOT_CHECKSUM_EN
   // Running XOR over every stream byte that precedes the checksum byte.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         xorAcc <= '0;
      end else if (accept && state != S_CHK) begin
         xorAcc <= xorAcc ^ rx_data;
      end
   end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a cycle-level vector table for the
// back-to-back load plus hand-written sequences for the multi-cycle cases.
module tb_imem_boot_loader;

   logic        clock;
   logic        reset;
   logic        rxValid;
   logic [7:0]  rxData;
   logic        rx_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        core_reset;
   logic        boot_done;
   logic        boot_error;

   int tests;
   int fails;
   int readyLow;

   logic [7:0]  wAddr[$];
   logic [31:0] wData[$];
   logic [7:0]  img[$];

   imem_boot_loader #(.ADDR_WIDTH(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .rx_valid   (rxValid),
      .rx_data    (rxData),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .boot_done  (boot_done),
      .boot_error (boot_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Write monitor, sampled away from the active edge.
   always @(negedge clock) begin
      if (imem_we === 1'b1) begin
         wAddr.push_back(imem_addr);
         wData.push_back(imem_wdata);
      end
   end

   typedef struct {
      logic        valid;
      logic [7:0]  data;
      logic        expWe;
      logic [7:0]  expAddr;
      logic [31:0] expWdata;
      logic        expReady;
      logic        expCoreReset;
      logic        expDone;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyReset();
      rxValid = 1'b0;
      rxData  = 8'h00;
      reset   = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      wAddr.delete();
      wData.delete();
   endtask

   // Offer one byte after 'gap' idle cycles and return just after the accepting edge.
   task automatic sendByte(input logic [7:0] b, input int gap);
      int waited;
      for (int i = 0; i < gap; i++) begin
         @(negedge clock);
         rxValid = 1'b0;
         if (rx_ready !== 1'b1) readyLow++;
      end
      @(negedge clock);
      rxValid = 1'b1;
      rxData  = b;
      waited  = 0;
      while (rx_ready !== 1'b1 && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      if (rx_ready !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL byte_accept_timeout: rx_ready %b, expected 1", rx_ready);
         rxValid = 1'b0;
      end else begin
         @(posedge clock);
      end
   endtask

   task automatic idleAfter(input int n);
      @(negedge clock);
      rxValid = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   initial begin
      vec_t vecs [12];
      tests    = 0;
      fails    = 0;
      readyLow = 0;
      rxValid  = 1'b0;
      rxData   = 8'h00;
      reset    = 1'b1;

      // Back-to-back N=2 image; expectations sampled 1 time unit after each edge.
      vecs[0]  = '{1'b1, 8'h02, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 8'h13, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 8'h00, 1'b1, 8'h00, 32'h00000013, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 8'h93, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 8'h50, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 1'b0};
`ifdef BOOT_CHECKSUM_EN
      vecs[9]  = '{1'b1, 8'h00, 1'b1, 8'h01, 32'h00500093, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 8'hD2, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 8'hFF, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b1};
`else
      vecs[9]  = '{1'b1, 8'h00, 1'b1, 8'h01, 32'h00500093, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 8'hFF, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b1};
`endif

      // Reset values while reset is held.
      repeat (2) @(negedge clock);
      check("rst_rx_ready",   32'(rx_ready),   32'd0);
      check("rst_imem_we",    32'(imem_we),    32'd0);
      check("rst_imem_addr",  32'(imem_addr),  32'd0);
      check("rst_imem_wdata", imem_wdata,      32'd0);
      check("rst_core_reset", 32'(core_reset), 32'd1);
      check("rst_boot_done",  32'(boot_done),  32'd0);
      check("rst_boot_error", 32'(boot_error), 32'd0);

      // Vector table: normal back-to-back load.
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("ready_after_reset", 32'(rx_ready), 32'd1);
      for (int i = 0; i < 12; i++) begin
         rxValid = vecs[i].valid;
         rxData  = vecs[i].data;
         @(posedge clock);
         #1;
         check($sformatf("vec%0d_we", i), 32'(imem_we), 32'(vecs[i].expWe));
         if (vecs[i].expWe) begin
            check($sformatf("vec%0d_addr", i),  32'(imem_addr), 32'(vecs[i].expAddr));
            check($sformatf("vec%0d_wdata", i), imem_wdata,     vecs[i].expWdata);
         end
         check($sformatf("vec%0d_ready", i),      32'(rx_ready),   32'(vecs[i].expReady));
         check($sformatf("vec%0d_core_reset", i), 32'(core_reset), 32'(vecs[i].expCoreReset));
         check($sformatf("vec%0d_done", i),       32'(boot_done),  32'(vecs[i].expDone));
      end
      rxValid = 1'b0;

      // Gapped stream: same image, random idle cycles between bytes.
      applyReset();
      img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
`ifdef BOOT_CHECKSUM_EN
      img.push_back(8'hD2);
`endif
      readyLow = 0;
      foreach (img[i]) sendByte(img[i], int'($urandom_range(0, 5)));
      idleAfter(3);
      check("gap_ready_held",  32'(readyLow),     32'd0);
      check("gap_write_count", 32'(wAddr.size()), 32'd2);
      if (wAddr.size() == 2) begin
         check("gap_w0_addr", 32'(wAddr[0]), 32'd0);
         check("gap_w0_data", wData[0],      32'h00000013);
         check("gap_w1_addr", 32'(wAddr[1]), 32'd1);
         check("gap_w1_data", wData[1],      32'h00500093);
      end
      check("gap_done",       32'(boot_done),  32'd1);
      check("gap_core_reset", 32'(core_reset), 32'd0);
      check("gap_ready_done", 32'(rx_ready),   32'd0);

`ifndef BOOT_CHECKSUM_EN
      // Zero-length image: release one edge after LEN_HI is accepted.
      applyReset();
      sendByte(8'h00, 0);
      sendByte(8'h00, 0);
      #1;
      check("zero_ready",        32'(rx_ready),  32'd0);
      check("zero_done_early",   32'(boot_done), 32'd0);
      @(posedge clock);
      #1;
      check("zero_done",         32'(boot_done),  32'd1);
      check("zero_core_reset",   32'(core_reset), 32'd0);
      idleAfter(2);
      check("zero_no_writes",    32'(wAddr.size()), 32'd0);
`endif

      // Overflow: N = 257 exceeds 256-word capacity.
      applyReset();
      sendByte(8'h01, 0);
      sendByte(8'h01, 0);
      #1;
      check("ovf_ready", 32'(rx_ready), 32'd0);
      idleAfter(3);
      check("ovf_error",      32'(boot_error),   32'd1);
      check("ovf_core_reset", 32'(core_reset),   32'd1);
      check("ovf_done",       32'(boot_done),    32'd0);
      check("ovf_ready_held", 32'(rx_ready),     32'd0);
      check("ovf_no_writes",  32'(wAddr.size()), 32'd0);

      // Mid-load reset after 6 bytes, then a fresh N=1 image.
      applyReset();
      img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
      foreach (img[i]) sendByte(img[i], 0);
      #1;
      check("mid_we_before_reset", 32'(imem_we), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_we",         32'(imem_we),    32'd0);
      check("mid_rst_addr",       32'(imem_addr),  32'd0);
      check("mid_rst_wdata",      imem_wdata,      32'd0);
      check("mid_rst_ready",      32'(rx_ready),   32'd0);
      check("mid_rst_core_reset", 32'(core_reset), 32'd1);
      applyReset();
      img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef BOOT_CHECKSUM_EN
      img.push_back(8'h09);
`endif
      foreach (img[i]) sendByte(img[i], 0);
      idleAfter(3);
      check("mid_write_count", 32'(wAddr.size()), 32'd1);
      if (wAddr.size() == 1) begin
         check("mid_w0_addr", 32'(wAddr[0]), 32'd0);
         check("mid_w0_data", wData[0],      32'h12345678);
      end
      check("mid_done",       32'(boot_done),  32'd1);
      check("mid_core_reset", 32'(core_reset), 32'd0);

`ifdef BOOT_CHECKSUM_EN
      // Checksum match and mismatch.
      applyReset();
      img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
      foreach (img[i]) sendByte(img[i], 0);
      idleAfter(3);
      check("chk_ok_done",       32'(boot_done),    32'd1);
      check("chk_ok_core_reset", 32'(core_reset),   32'd0);
      check("chk_ok_writes",     32'(wAddr.size()), 32'd1);
      applyReset();
      img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
      foreach (img[i]) sendByte(img[i], 0);
      idleAfter(3);
      check("chk_bad_error",      32'(boot_error),   32'd1);
      check("chk_bad_core_reset", 32'(core_reset),   32'd1);
      check("chk_bad_done",       32'(boot_done),    32'd0);
      check("chk_bad_writes",     32'(wAddr.size()), 32'd1);
      if (wAddr.size() == 1) check("chk_bad_w0_data", wData[0], 32'h00000013);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
